// File: rtl/btn_pkg.sv
// Shared constants, FSM state type and counter-width helpers for the
// push-button conditioner.
package btn_pkg;

    localparam int unsigned DEF_DB_CYCLES    = 250000;
    localparam int unsigned DEF_REPEAT_DELAY = 25000000;
    localparam int unsigned DEF_REPEAT_RATE  = 5000000;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } rep_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce counter and the
// press / auto-repeat FSM with registered pulse outputs.
module btn_channel
    import btn_pkg::*;
#(
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DB_CYCLES    = DEF_DB_CYCLES,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic rep_en,
    output logic btn_level,
    output logic press,
    output logic released,
    output logic push
);

    localparam int unsigned DW = cnt_width(DB_CYCLES);
    localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));

    localparam logic          IDLE_LVL   = ACTIVE_LOW;
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [1:0]    sync;
    logic          s;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nxt;
    logic          accept;
    rep_state_t    state;
    rep_state_t    state_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    logic          push_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{IDLE_LVL}};
        end else begin
            sync <= {sync[0], btn_raw};
        end
    end

    assign s = sync[1] ^ IDLE_LVL;

    // accept marks the cycle the debounced level flips; its direction is
    // given by the level before the flip.
    always_comb begin
        accept   = 1'b0;
        dcnt_nxt = '0;
        if (s != btn_level) begin
            if (dcnt == DB_LAST) begin
                accept = 1'b1;
            end else begin
                dcnt_nxt = dcnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        push_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = HELD;
                    push_nxt  = 1'b1;
                    rcnt_nxt  = '0;
                end
            end
            HELD: begin
                if (accept) begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end else if (!rep_en) begin
                    rcnt_nxt = '0;
                end else if (rcnt == DELAY_LAST) begin
                    state_nxt = REPEAT;
                    push_nxt  = 1'b1;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (accept) begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end else if (!rep_en) begin
                    state_nxt = HELD;
                    rcnt_nxt  = '0;
                end else if (rcnt == RATE_LAST) begin
                    push_nxt = 1'b1;
                    rcnt_nxt = '0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                rcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt      <= '0;
            btn_level <= 1'b0;
            press     <= 1'b0;
            released  <= 1'b0;
            push      <= 1'b0;
            state     <= IDLE;
            rcnt      <= '0;
        end else begin
            dcnt      <= dcnt_nxt;
            btn_level <= btn_level ^ accept;
            press     <= accept & ~btn_level;
            released  <= accept & btn_level;
            push      <= push_nxt;
            state     <= state_nxt;
            rcnt      <= rcnt_nxt;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end; each channel is an independent
// btn_channel instance.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN        = 3,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DB_CYCLES    = DEF_DB_CYCLES,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rep_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] released,
    output logic [N_BTN-1:0] push
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw   (btn_raw[i]),
            .rep_en    (rep_en[i]),
            .btn_level (btn_level[i]),
            .press     (press[i]),
            .released  (released[i]),
            .push      (push[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: directed scenarios followed by
// random pad activity, checked against a run-length reference model.
module tb_button_conditioner;

    localparam int unsigned N_BTN = 3;
    localparam int unsigned DB    = 4;
    localparam int unsigned RD    = 10;
    localparam int unsigned RR    = 3;

    logic             clk = 1'b1;
    logic             rst_n = 1'b0;
    logic [N_BTN-1:0] btn_raw = '1;
    logic [N_BTN-1:0] rep_en = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] released;
    logic [N_BTN-1:0] push;

    button_conditioner #(
        .N_BTN        (N_BTN),
        .ACTIVE_LOW   (1'b1),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .rep_en    (rep_en),
        .btn_level (btn_level),
        .press     (press),
        .released  (released),
        .push      (push)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_BTN-1:0] lvl;
        logic [N_BTN-1:0] prs;
        logic [N_BTN-1:0] rel;
        logic [N_BTN-1:0] psh;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_no = 0;
    int   last_tick_edge = 0;

    int   press0_edge = -1;
    int   rel0_cnt = 0;
    int   rel2_edge = -1;
    int   rel2_push = -1;
    int   push2_log[$];

    // Reference model: pad history (two edges of delay), accepted level,
    // run length of disagreeing samples, and run length of enabled hold time.
    logic [N_BTN-1:0] m_p1, m_p2, m_lvl;
    int               m_diff[N_BTN];
    int               m_run[N_BTN];

    task automatic model_reset();
        m_p1  = '1;
        m_p2  = '1;
        m_lvl = '0;
        for (int c = 0; c < N_BTN; c++) begin
            m_diff[c] = 0;
            m_run[c]  = 0;
        end
    endtask

    task automatic model_edge(input logic [N_BTN-1:0] raw, input logic [N_BTN-1:0] rep,
                              output exp_t e);
        e = '0;
        for (int c = 0; c < N_BTN; c++) begin
            logic s;
            logic tog;
            s   = ~m_p2[c];
            tog = 1'b0;
            if (s != m_lvl[c]) begin
                m_diff[c]++;
                if (m_diff[c] == DB) begin
                    tog       = 1'b1;
                    m_lvl[c]  = ~m_lvl[c];
                    m_diff[c] = 0;
                end
            end else begin
                m_diff[c] = 0;
            end
            e.lvl[c] = m_lvl[c];
            e.prs[c] = tog & m_lvl[c];
            e.rel[c] = tog & ~m_lvl[c];
            if (e.prs[c]) begin
                m_run[c] = 0;
                e.psh[c] = 1'b1;
            end else if (e.rel[c] || !m_lvl[c] || !rep[c]) begin
                m_run[c] = 0;
            end else begin
                m_run[c]++;
                e.psh[c] = (m_run[c] == RD) ||
                           (m_run[c] > RD && ((m_run[c] - RD) % RR) == 0);
            end
        end
        m_p2 = m_p1;
        m_p1 = raw;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic tick(input logic r, input logic [N_BTN-1:0] raw, input logic [N_BTN-1:0] rep);
        exp_t e;
        @(negedge clk);
        rst_n          = r;
        btn_raw        = raw;
        rep_en         = rep;
        last_tick_edge = edge_no + 1;
        if (!r) begin
            model_reset();
            e = '0;
        end else begin
            model_edge(raw, rep, e);
        end
        sb.push_back(e);
    endtask

    task automatic do_reset(input int n, input logic [N_BTN-1:0] raw, input logic [N_BTN-1:0] rep);
        @(negedge clk);
        rst_n          = 1'b0;
        btn_raw        = raw;
        rep_en         = rep;
        last_tick_edge = edge_no + 1;
        #1;
        check("reset_immediate", int'({btn_level, press, released, push}), 0);
        model_reset();
        sb.push_back('0);
        for (int i = 1; i < n; i++) tick(1'b0, raw, rep);
    endtask

    // Monitor: one output sample per rising edge, popped against the scoreboard.
    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            got = {btn_level, press, released, push};
            if (press[0]) press0_edge = edge_no;
            if (released[0]) rel0_cnt++;
            if (push[2]) push2_log.push_back(edge_no);
            if (released[2]) begin
                rel2_edge = edge_no;
                rel2_push = int'(push[2]);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty at edge %0d: got %h, want an expected entry",
                         edge_no, got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL outputs edge %0d: got lvl=%b prs=%b rel=%b psh=%b, want lvl=%b prs=%b rel=%b psh=%b",
                             edge_no, got.lvl, got.prs, got.rel, got.psh,
                             want.lvl, want.prs, want.rel, want.psh);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_BTN-1:0] raw;
        logic [N_BTN-1:0] rep;
        int e0;
        int e1;
        int first;

        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 3'b111, 3'b000);
        for (int i = 0; i < 3; i++) tick(1'b1, 3'b111, 3'b000);

        // Clean press on channel 0.
        press0_edge = -1;
        tick(1'b1, 3'b110, 3'b000);
        e0 = last_tick_edge;
        for (int i = 0; i < 9; i++) tick(1'b1, 3'b110, 3'b000);
        check("press_latency", press0_edge - e0, 5);
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b111, 3'b000);

        // Bounce and short glitch on channel 1 (pad 1 is idle).
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 3'b101, 3'b000);
            tick(1'b1, 3'b101, 3'b000);
            tick(1'b1, 3'b111, 3'b000);
            tick(1'b1, 3'b111, 3'b000);
        end
        for (int i = 0; i < 6; i++) tick(1'b1, 3'b111, 3'b000);
        for (int i = 0; i < 3; i++) tick(1'b1, 3'b101, 3'b000);
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b111, 3'b000);

        // Auto-repeat on channel 2.
        push2_log.delete();
        tick(1'b1, 3'b011, 3'b100);
        e0 = last_tick_edge;
        for (int i = 0; i < 44; i++) tick(1'b1, 3'b011, 3'b100);
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b111, 3'b100);
        if (push2_log.size() < 4) begin
            check("repeat_push_count", push2_log.size(), 4);
        end else begin
            check("repeat_first_push", push2_log[0] - e0, 5);
            check("repeat_delay", push2_log[1] - push2_log[0], int'(RD));
            check("repeat_rate_a", push2_log[2] - push2_log[1], int'(RR));
            check("repeat_rate_b", push2_log[3] - push2_log[2], int'(RR));
        end

        // Repeat disable and re-enable on channel 2.
        push2_log.delete();
        for (int i = 0; i < 20; i++) tick(1'b1, 3'b011, 3'b100);
        for (int i = 0; i < 6; i++) tick(1'b1, 3'b011, 3'b000);
        tick(1'b1, 3'b011, 3'b100);
        e1 = last_tick_edge;
        for (int i = 0; i < 19; i++) tick(1'b1, 3'b011, 3'b100);
        first = -1;
        foreach (push2_log[k]) if (push2_log[k] >= e1 && first < 0) first = push2_log[k];
        check("reenable_gap", first - (e1 - 1), int'(RD));
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b111, 3'b100);

        // Release accepted on the same edge a repeat would fire.
        rel2_edge = -1;
        tick(1'b1, 3'b011, 3'b100);
        e0 = last_tick_edge;
        for (int i = 0; i < 15; i++) tick(1'b1, 3'b011, 3'b100);
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b111, 3'b100);
        check("collide_release_edge", rel2_edge - e0, 21);
        check("collide_push", rel2_push, 0);

        // Reset while channel 0 is auto-repeating, button still held afterwards.
        for (int i = 0; i < 20; i++) tick(1'b1, 3'b110, 3'b001);
        rel0_cnt    = 0;
        press0_edge = -1;
        do_reset(2, 3'b110, 3'b001);
        tick(1'b1, 3'b110, 3'b001);
        e1 = last_tick_edge;
        for (int i = 0; i < 9; i++) tick(1'b1, 3'b110, 3'b001);
        check("post_reset_press", press0_edge - e1, 5);
        check("post_reset_no_release", rel0_cnt, 0);
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b111, 3'b000);

        // Random pad, enable and occasional reset activity.
        raw = 3'b111;
        rep = 3'b000;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_BTN; c++) begin
                if ($urandom_range(0, 11) == 0) raw[c] = ~raw[c];
                if ($urandom_range(0, 49) == 0) rep[c] = ~rep[c];
            end
            if ($urandom_range(0, 599) == 0) do_reset(2, raw, rep);
            else tick(1'b1, raw, rep);
        end

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel front end for board push-buttons. Per channel it synchronises, debounces and edge-detects the raw pad signal, and can auto-repeat while a key is held. It sits directly upstream of the LED shift-register stage, which consumes its single-cycle `push` pulses in place of raw button edges. All outputs are active-high regardless of pad polarity.

Parameters:
- N_BTN, 3, number of button channels.
- ACTIVE_LOW, 1, 1 means the pad reads 0 when pressed; 0 means the pad reads 1 when pressed.
- DB_CYCLES, 250000, consecutive stable synchronised cycles required to accept a level change (5 ms at 50 MHz); must be ≥ 2.
- REPEAT_DELAY, 25000000, cycles from the press pulse to the first auto-repeat pulse (0.5 s); must be ≥ 2.
- REPEAT_RATE, 5000000, cycles between later auto-repeat pulses (0.1 s); must be ≥ 2.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- btn_raw  in  N_BTN  raw asynchronous button pads.
- rep_en  in  N_BTN  per-channel auto-repeat enable; quasi-static; read every cycle.
- btn_level  out  N_BTN  debounced pressed state; 1 = pressed.
- press  out  N_BTN  1-cycle pulse on accepted press.
- release  out  N_BTN  1-cycle pulse on accepted release.
- push  out  N_BTN  1-cycle pulse on press OR auto-repeat; this is the downstream strobe.

Behaviour:
Reset (async, rst_n=0):
- Synchroniser flops are set to the pad's inactive level (1 if ACTIVE_LOW).
- All counters are cleared and every FSM goes to IDLE.
- btn_level, press, release and push are all 0.

Synchroniser:
- Two flops per channel, then polarity normalisation.
- The result `s` is 1 when pressed.

Debounce (per channel):
- Counter `dcnt` of width $clog2(DB_CYCLES).
- Each edge: if s == btn_level, dcnt <= 0.
- Otherwise, if dcnt == DB_CYCLES-1: btn_level toggles, dcnt <= 0, and the matching press/release pulse is asserted.
- Otherwise dcnt <= dcnt+1.
- Latency: a raw transition captured at edge 0 and held stable updates btn_level and the pulse at edge DB_CYCLES+1.
- A glitch shorter than DB_CYCLES synchronised cycles produces no output and no change.

Per-channel FSM (states IDLE, HELD, REPEAT):
- IDLE: on an accepted press go to HELD; push=1 that cycle; repeat counter rcnt <= 0.
- HELD:
  - On an accepted release go to IDLE.
  - Else if rep_en=0, hold rcnt at 0.
  - Else rcnt increments. When rcnt == REPEAT_DELAY-1: push=1, rcnt <= 0, go to REPEAT.
- REPEAT:
  - On an accepted release go to IDLE.
  - Else if rep_en=0, go to HELD with rcnt <= 0.
  - Else when rcnt == REPEAT_RATE-1: push=1, rcnt <= 0. Otherwise rcnt increments.
- rcnt width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)).

Boundary rules:
- Release has priority over a repeat pulse in the same cycle: release=1, push=0.
- press, release and push are never high for more than 1 consecutive cycle from a single event.
- press and release are mutually exclusive per channel.
- Channels are fully independent; simultaneous presses on all channels give simultaneous pulses.
- Reset mid-hold: all outputs drop immediately. A button still held after reset is re-accepted as a new press DB_CYCLES+1 edges after the first clock edge following reset release.
- Counters never wrap; they are always cleared at their terminal values.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Package `btn_pkg`: default constants for DB_CYCLES, REPEAT_DELAY and REPEAT_RATE, the FSM state enum (IDLE/HELD/REPEAT), and a function for the counter-width calculation.
- Sub-module `btn_channel`: one channel containing the synchroniser, debounce counter, FSM and repeat counter.
- button_conditioner instantiates `btn_channel` N_BTN times in a generate loop.

Test Plan:
All tests use N_BTN=3, ACTIVE_LOW=1, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Clean press: btn_raw[0] 1→0 captured at edge 0 and held → btn_level[0]=1, press[0]=1 and push[0]=1 at edge 5, each for exactly 1 cycle. Channels 1 and 2 stay 0.
- Bounce: btn_raw[1] toggles 0/1/0/1 with 2-cycle widths, then stays 1 → no pulses ever and btn_level[1] stays 0. A 3-cycle-low glitch likewise produces nothing.
- Auto-repeat: rep_en[2]=1, channel 2 held 40 cycles after acceptance at edge P → push[2] high at P, P+10, P+13, P+16, …. press[2] high only at P. On release, release[2] pulses once and push stops.
- Repeat disable: while in REPEAT, drop rep_en[2] → no further push. Re-raise it → next push exactly 10 cycles later.
- Release vs repeat collision: time the release acceptance to land on the cycle a repeat would fire → release=1, push=0 in that cycle.
- Reset mid-hold: assert rst_n=0 while channel 0 is held in REPEAT → all outputs 0 immediately. Release reset with the button still held → press[0] fires 5 edges later, with no spurious release.
